pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12, SHALL set the PC and instruction-memory address width in words.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low; reset==0 SHALL force reset state immediately, independent of clock.
REQ-005 Port instr, input, 32: instruction word from imem, sampled only when imem_ready==1 in FETCH.
REQ-006 Port imem_ready, input, 1: instr is valid this cycle.
REQ-007 Port op_rd, input, 32: regfile value of $rd for the latched instruction.
REQ-008 Port op_rs, input, 32: regfile value of $rs for the latched instruction.
REQ-009 Port status, input, 32: regfile value of $r30 (rstatus).
REQ-010 Port hold, input, 1: datapath busy (e.g. multdiv); PC SHALL NOT advance while high.
REQ-011 Port pc, output, PC_W: current instruction address to imem.
REQ-012 Port fetch_req, output, 1: high in FETCH state only.
REQ-013 Port ir, output, 32: latched instruction register.
REQ-014 Port exec_valid, output, 1: one-cycle pulse when the instruction in ir retires and PC updates.
REQ-015 Port redirect, output, 1: high with exec_valid when the retired instruction changed control flow.
REQ-016 Port link_we, output, 1: high with exec_valid for jal only; link_data, output, 32: zero-extended PC+1 for the $r31 write.

Function
REQ-017 States SHALL be FETCH, EXEC, HOLD; reset state FETCH.
REQ-018 FETCH: fetch_req=1; on imem_ready==1, ir<=instr, go EXEC; otherwise stay with pc unchanged.
REQ-019 EXEC: hold==1 -> HOLD with no retirement; hold==0 -> pc<=next_pc, exec_valid=1, go FETCH.
REQ-020 HOLD: stay while hold==1; when hold==0, retire exactly as in EXEC in that same cycle.
REQ-021 Minimum latency SHALL be 2 cycles per instruction (FETCH with imem_ready=1, then EXEC with hold=0).
REQ-022 Decode: opcode=ir[31:27], rd=ir[26:22], rs=ir[21:17], N=ir[16:0] sign-extended, T=ir[26:0].
REQ-023 j (00001): next_pc=T[PC_W-1:0], redirect=1.
REQ-024 jal (00011): next_pc=T[PC_W-1:0], link_data=PC+1, link_we=1, redirect=1.
REQ-025 jr (00100): next_pc=op_rd[PC_W-1:0], redirect=1.
REQ-026 bne (00010): op_rd!=op_rs -> next_pc=PC+1+N, redirect=1; else PC+1.
REQ-027 blt (00110): signed op_rd<op_rs -> next_pc=PC+1+N, redirect=1; else PC+1.
REQ-028 bex (10110): status!=0 -> next_pc=T[PC_W-1:0], redirect=1; else PC+1.
REQ-029 All other opcodes, including setx (10101): next_pc=PC+1, redirect=0.
REQ-030 PC arithmetic SHALL be modulo 2^PC_W; PC=2^PC_W-1 plus 1 wraps to 0; negative N below 0 wraps.
REQ-031 exec_valid, redirect, link_we SHALL be 0 in FETCH and while hold==1.

Reset
REQ-032 reset==0 SHALL set pc=RESET_PC, state=FETCH, ir=0, exec_valid=0, redirect=0, link_we=0, link_data=0, fetch_req=1 after release.
REQ-033 Reset asserted in EXEC or HOLD SHALL discard the pending instruction without retirement or link write.

Configuration
REQ-034 Macro PC_SEQUENCER_INSTRET_EN defined: output instret, 32, counts exec_valid pulses, reset to 0, wraps 0xFFFFFFFF->0.
REQ-035 Macro undefined: instret port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-036 Opcode constants and the state enum SHALL live in shared package proc_pkg.
REQ-037 Branch/next-PC evaluation SHALL be one combinational sub-module, next_pc_unit; FSM and registers stay in pc_sequencer.

Verification
REQ-038 Reset release, imem_ready=1, hold=0, three add instructions -> pc 0,1,2,3 with exec_valid every second cycle.
REQ-039 pc=3, jal T=20 -> pc=20, link_we=1, link_data=4; then jr with op_rd=4 -> pc=4, redirect=1.
REQ-040 pc=10, bne N=5: op_rd=10,op_rs=20 -> pc=16; op_rd=op_rs=7 -> pc=11. blt N=-3, op_rd=-1, op_rs=2, pc=10 -> pc=8.
REQ-041 bex T=40, status=2 -> pc=40; status=0 -> pc+1; setx -> pc+1, redirect=0.
REQ-042 hold=1 for 4 cycles in EXEC -> pc stable, no exec_valid; single pulse on hold release; imem_ready low 3 cycles -> fetch_req held, pc stable.
REQ-043 pc=4095 non-branch -> pc=0; reset pulsed low in HOLD -> pc=RESET_PC, no link_we, instret (if enabled) unchanged by discarded instruction then 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode constants and sequencer state encoding for the instruction
// fetch/retire sequencer and its next-PC evaluator.
package proc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC evaluation for the instruction held in ir: jumps,
// register jump, conditional branches and the jal link value.
module next_pc_unit
    import proc_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     ir,
    input  logic [31:0]     op_rd,
    input  logic [31:0]     op_rs,
    input  logic [31:0]     status,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            link,
    output logic [31:0]     link_data
);

    logic [4:0]      opcode;
    logic [31:0]     n_ext;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] target;
    logic            unused_bits;

    assign opcode    = ir[31:27];
    assign n_ext     = {{15{ir[16]}}, ir[16:0]};
    // All PC arithmetic is PC_W wide, so overflow and negative offsets wrap.
    assign pc_seq    = pc + PC_W'(1);
    assign pc_branch = pc_seq + n_ext[PC_W-1:0];
    assign target    = ir[PC_W-1:0];
    assign unused_bits = ^{ir, n_ext};

    always_comb begin
        next_pc   = pc_seq;
        redirect  = 1'b0;
        link      = 1'b0;
        link_data = '0;
        case (opcode)
            OP_J: begin
                next_pc  = target;
                redirect = 1'b1;
            end
            OP_JAL: begin
                next_pc   = target;
                redirect  = 1'b1;
                link      = 1'b1;
                link_data = {{(32-PC_W){1'b0}}, pc_seq};
            end
            OP_JR: begin
                next_pc  = op_rd[PC_W-1:0];
                redirect = 1'b1;
            end
            OP_BNE: begin
                if (op_rd != op_rs) begin
                    next_pc  = pc_branch;
                    redirect = 1'b1;
                end
            end
            OP_BLT: begin
                if ($signed(op_rd) < $signed(op_rs)) begin
                    next_pc  = pc_branch;
                    redirect = 1'b1;
                end
            end
            OP_BEX: begin
                if (status != 32'd0) begin
                    next_pc  = target;
                    redirect = 1'b1;
                end
            end
            OP_SETX: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/hold sequencer owning pc and ir; optional retired-instruction
// counter enabled by defining PC_SEQUENCER_INSTRET_EN.
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            imem_ready,
    input  logic [31:0]     op_rd,
    input  logic [31:0]     op_rs,
    input  logic [31:0]     status,
    input  logic            hold,
    output logic [PC_W-1:0] pc,
    output logic            fetch_req,
    output logic [31:0]     ir,
    output logic            exec_valid,
    output logic            redirect,
    output logic            link_we,
    output logic [31:0]     link_data,
`ifdef PC_SEQUENCER_INSTRET_EN
    output logic [31:0]     instret,
`endif
    output state_e          dbg_state
);

    // Handshake: instr is accepted on any cycle where fetch_req && imem_ready;
    // the datapath stalls retirement by holding hold high, without a timeout.

    state_e          state, state_next;
    logic            retire;
    logic [PC_W-1:0] npc;
    logic            npc_redirect;
    logic            npc_link;
    logic [31:0]     npc_link_data;

    next_pc_unit #(.PC_W(PC_W)) u_next_pc (
        .pc        (pc),
        .ir        (ir),
        .op_rd     (op_rd),
        .op_rs     (op_rs),
        .status    (status),
        .next_pc   (npc),
        .redirect  (npc_redirect),
        .link      (npc_link),
        .link_data (npc_link_data)
    );

    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready) state_next = EXEC;
            end
            EXEC, HOLD: begin
                if (hold) begin
                    state_next = HOLD;
                end else begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign exec_valid = retire;
    assign redirect   = retire & npc_redirect;
    assign link_we    = retire & npc_link;
    assign link_data  = retire ? npc_link_data : 32'd0;
    assign dbg_state  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ready) ir <= instr;
            if (retire) pc <= npc;
        end
    end

`ifdef PC_SEQUENCER_INSTRET_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// hold/stall/reset sequences and random instructions against an arithmetic model.
module tb_pc_sequencer;
    import proc_pkg::*;

    localparam int PCM = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr, op_rd, op_rs, status;
    logic        imem_ready, hold;
    logic [11:0] pc;
    logic        fetch_req, exec_valid, redirect, link_we;
    logic [31:0] ir, link_data;
    state_e      dbg_state;
`ifdef PC_SEQUENCER_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int errors = 0;
    int model_pc = 0;
    int exp_instret = 0;

    pc_sequencer #(.PC_W(12), .RESET_PC(12'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .imem_ready (imem_ready),
        .op_rd      (op_rd),
        .op_rs      (op_rs),
        .status     (status),
        .hold       (hold),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .ir         (ir),
        .exec_valid (exec_valid),
        .redirect   (redirect),
        .link_we    (link_we),
        .link_data  (link_data),
`ifdef PC_SEQUENCER_INSTRET_EN
        .instret    (instret),
`endif
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          start_pc;
        logic [31:0] ins;
        logic [31:0] rd;
        logic [31:0] rs;
        logic [31:0] st;
        int          exp_pc;
        logic        exp_red;
        logic        exp_lwe;
        logic [31:0] exp_ld;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_t(input logic [4:0] op, input int t);
        logic [26:0] tt;
        tt = 27'(t);
        return {op, tt};
    endfunction

    function automatic logic [31:0] mk_n(input logic [4:0] op, input int n);
        logic [16:0] nn;
        nn = 17'(n);
        return {op, 10'd0, nn};
    endfunction

    // Architectural next-PC rules evaluated with integer modulo arithmetic.
    function automatic void model(input int cur, input logic [31:0] ins, input logic [31:0] rd,
                                  input logic [31:0] rs, input logic [31:0] st, output int npc,
                                  output logic red, output logic lwe, output logic [31:0] ld);
        int n, seq, tgt, br;
        int op;
        op  = int'(ins[31:27]);
        n   = int'(ins[16:0]);
        if (ins[16]) n = n - 131072;
        seq = (cur + 1) % PCM;
        tgt = int'(ins[26:0]) % PCM;
        br  = (((cur + 1 + n) % PCM) + PCM) % PCM;
        npc = seq; red = 1'b0; lwe = 1'b0; ld = 32'd0;
        case (op)
            1: begin npc = tgt; red = 1'b1; end
            3: begin npc = tgt; red = 1'b1; lwe = 1'b1; ld = 32'(seq); end
            4: begin npc = int'(rd % 32'(PCM)); red = 1'b1; end
            2: if (rd != rs) begin npc = br; red = 1'b1; end
            6: if ($signed(rd) < $signed(rs)) begin npc = br; red = 1'b1; end
            22: if (st != 0) begin npc = tgt; red = 1'b1; end
            default: ;
        endcase
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; returns with the
    // instruction retired, again just after a rising edge.
    task automatic exec_one(input logic [31:0] ins, input logic [31:0] rd, input logic [31:0] rs,
                            input logic [31:0] st, input int hold_cycles, output logic ev,
                            output logic rdr, output logic lwe, output logic [31:0] ld,
                            output int npc);
        instr = ins; imem_ready = 1'b1; hold = 1'b0;
        op_rd = rd; op_rs = rs; status = st;
        @(negedge clock);
        check("fetch_req_in_fetch", 32'(fetch_req), 32'd1);
        check("exec_valid_in_fetch", 32'(exec_valid), 32'd0);
        @(posedge clock); #1;
        imem_ready = 1'b0; instr = $urandom;
        for (int h = 0; h < hold_cycles; h++) begin
            hold = 1'b1;
            @(negedge clock);
            check("exec_valid_while_hold", 32'(exec_valid), 32'd0);
            check("link_we_while_hold", 32'(link_we), 32'd0);
            check("pc_stable_while_hold", 32'(pc), 32'(model_pc));
            @(posedge clock); #1;
        end
        hold = 1'b0;
        @(negedge clock);
        check("fetch_req_in_exec", 32'(fetch_req), 32'd0);
        ev = exec_valid; rdr = redirect; lwe = link_we; ld = link_data;
        @(posedge clock); #1;
        npc = int'(pc);
        exp_instret++;
    endtask

    task automatic goto_pc(input int target);
        logic ev, rdr, lwe;
        logic [31:0] ld;
        int npc;
        exec_one(mk_t(OP_J, target), 32'd0, 32'd0, 32'd0, 0, ev, rdr, lwe, ld, npc);
        check("goto_pc", 32'(npc), 32'(target));
        model_pc = target;
    endtask

    vec_t vecs[13];

    initial begin
        logic ev, rdr, lwe;
        logic [31:0] ld, ins, rd, rs, st;
        int npc, epc, hc;
        logic ered, elwe;
        logic [31:0] eld;

        vecs[0]  = '{3,    mk_t(OP_JAL, 20),     0,            0,  0, 20,   1, 1, 4};
        vecs[1]  = '{20,   mk_t(OP_JR, 0),       4,            0,  0, 4,    1, 0, 0};
        vecs[2]  = '{10,   mk_n(OP_BNE, 5),      10,           20, 0, 16,   1, 0, 0};
        vecs[3]  = '{10,   mk_n(OP_BNE, 5),      7,            7,  0, 11,   0, 0, 0};
        vecs[4]  = '{10,   mk_n(OP_BLT, -3),     32'hFFFFFFFF, 2,  0, 8,    1, 0, 0};
        vecs[5]  = '{10,   mk_t(OP_BEX, 40),     0,            0,  2, 40,   1, 0, 0};
        vecs[6]  = '{10,   mk_t(OP_BEX, 40),     0,            0,  0, 11,   0, 0, 0};
        vecs[7]  = '{10,   mk_t(OP_SETX, 1234),  0,            0,  5, 11,   0, 0, 0};
        vecs[8]  = '{4095, 32'h0000_0123,        0,            0,  0, 0,    0, 0, 0};
        vecs[9]  = '{4095, mk_t(OP_JAL, 5),      0,            0,  0, 5,    1, 1, 0};
        vecs[10] = '{0,    mk_n(OP_BNE, -2),     1,            2,  0, 4095, 1, 0, 0};
        vecs[11] = '{0,    mk_t(OP_J, 27'h7FFFFFF), 0,         0,  0, 4095, 1, 0, 0};
        vecs[12] = '{10,   mk_n(OP_BLT, 5),      2, 32'hFFFFFFFF,  0, 11,   0, 0, 0};

        reset = 1'b0; instr = 0; imem_ready = 0; hold = 0; op_rd = 0; op_rs = 0; status = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_fetch_req", 32'(fetch_req), 32'd1);
        check("rst_exec_valid", 32'(exec_valid), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_link_we", 32'(link_we), 32'd0);
        check("rst_link_data", link_data, 32'd0);
        @(posedge clock); #1;

        // Three back-to-back adds from reset.
        for (int i = 1; i <= 3; i++) begin
            exec_one(32'h0000_0000 | 32'(i), 0, 0, 0, 0, ev, rdr, lwe, ld, npc);
            check($sformatf("add%0d_ev", i), 32'(ev), 32'd1);
            check($sformatf("add%0d_redirect", i), 32'(rdr), 32'd0);
            check($sformatf("add%0d_pc", i), 32'(npc), 32'(i));
        end
        model_pc = 3;

        for (int i = 0; i < 13; i++) begin
            goto_pc(vecs[i].start_pc);
            exec_one(vecs[i].ins, vecs[i].rd, vecs[i].rs, vecs[i].st, 0, ev, rdr, lwe, ld, npc);
            check($sformatf("vec%0d_ev", i), 32'(ev), 32'd1);
            check($sformatf("vec%0d_pc", i), 32'(npc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_redirect", i), 32'(rdr), 32'(vecs[i].exp_red));
            check($sformatf("vec%0d_link_we", i), 32'(lwe), 32'(vecs[i].exp_lwe));
            check($sformatf("vec%0d_link_data", i), ld, vecs[i].exp_ld);
            model_pc = vecs[i].exp_pc;
        end

        // Four-cycle hold in EXEC followed by a single retirement pulse.
        exec_one(32'h0000_0000, 0, 0, 0, 4, ev, rdr, lwe, ld, npc);
        check("hold_release_ev", 32'(ev), 32'd1);
        check("hold_release_pc", 32'(npc), 32'((model_pc + 1) % PCM));
        model_pc = (model_pc + 1) % PCM;

        // imem not ready for three cycles: stay in FETCH, pc unchanged.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_fetch_req", 32'(fetch_req), 32'd1);
            check("stall_pc", 32'(pc), 32'(model_pc));
            check("stall_exec_valid", 32'(exec_valid), 32'd0);
            @(posedge clock); #1;
        end

        for (int i = 0; i < 200; i++) begin
            rd = $urandom; rs = $urandom_range(0, 1) ? rd : $urandom;
            st = $urandom_range(0, 1) ? 32'd0 : $urandom;
            case ($urandom_range(0, 8))
                0: ins = {5'b00000, 27'($urandom)};
                1: ins = mk_t(OP_J, int'($urandom));
                2: ins = mk_t(OP_JAL, int'($urandom));
                3: ins = mk_t(OP_JR, int'($urandom));
                4: ins = mk_n(OP_BNE, int'($urandom));
                5: ins = mk_n(OP_BLT, int'($urandom));
                6: ins = mk_t(OP_BEX, int'($urandom));
                7: ins = mk_t(OP_SETX, int'($urandom));
                default: ins = $urandom;
            endcase
            hc = $urandom_range(0, 2);
            model(model_pc, ins, rd, rs, st, epc, ered, elwe, eld);
            exec_one(ins, rd, rs, st, hc, ev, rdr, lwe, ld, npc);
            check("rand_ev", 32'(ev), 32'd1);
            check("rand_pc", 32'(npc), 32'(epc));
            check("rand_redirect", 32'(rdr), 32'(ered));
            check("rand_link_we", 32'(lwe), 32'(elwe));
            check("rand_link_data", ld, eld);
            model_pc = epc;
        end

        // Reset asserted while a jal waits in HOLD: discarded, no link write.
        instr = mk_t(OP_JAL, 100); imem_ready = 1'b1; hold = 1'b1;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("hold_state", 32'(dbg_state), 32'(HOLD));
        check("hold_link_we", 32'(link_we), 32'd0);
`ifdef PC_SEQUENCER_INSTRET_EN
        check("instret_before_reset", instret, 32'(exp_instret));
`endif
        #2 reset = 1'b0;
        #1;
        check("hold_rst_pc", 32'(pc), 32'd0);
        check("hold_rst_link_we", 32'(link_we), 32'd0);
        check("hold_rst_exec_valid", 32'(exec_valid), 32'd0);
        check("hold_rst_ir", ir, 32'd0);
        check("hold_rst_fetch_req", 32'(fetch_req), 32'd1);
`ifdef PC_SEQUENCER_INSTRET_EN
        check("instret_after_reset", instret, 32'd0);
`endif
        @(posedge clock); #1;
        hold = 1'b0; reset = 1'b1; model_pc = 0; exp_instret = 0;
        exec_one(32'h0000_0000, 0, 0, 0, 0, ev, rdr, lwe, ld, npc);
        check("post_reset_pc", 32'(npc), 32'd1);
`ifdef PC_SEQUENCER_INSTRET_EN
        check("instret_post_reset", instret, 32'(exp_instret));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
